// File: rtl/pc_fetch_stage_pkg.sv
// rtl/pc_fetch_stage_pkg.sv - shared fetch-stage types and constants
package pc_fetch_stage_pkg;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;

   function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/pc_fetch_stage_if.sv
// rtl/pc_fetch_stage_if.sv - control, imem and IF/ID bundle of the fetch stage
interface pc_fetch_stage_if;
   logic [31:0] PCNext;
   logic        PCWrite;
   logic        IFIDWrite;
   logic        IFIDFlush;
   logic [31:0] Instruction;
   logic [31:0] PCAddr;
   logic [31:0] PCPlus4;
   logic [31:0] IFID_Instruction;
   logic [31:0] IFID_PCPlus4;
   logic        IFID_Valid;
   logic        Halted;
   logic [31:0] FetchCount;

   modport master (
      output PCNext, PCWrite, IFIDWrite, IFIDFlush, Instruction,
      input  PCAddr, PCPlus4, IFID_Instruction, IFID_PCPlus4, IFID_Valid,
             Halted, FetchCount
   );

   modport slave (
      input  PCNext, PCWrite, IFIDWrite, IFIDFlush, Instruction,
      output PCAddr, PCPlus4, IFID_Instruction, IFID_PCPlus4, IFID_Valid,
             Halted, FetchCount
   );
endinterface

// File: rtl/pc_fetch_stage_if_id_register.sv
// rtl/pc_fetch_stage_if_id_register.sv - IF/ID pipeline register with write, flush and async reset
module if_id_register
   import pc_fetch_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        write,
   input  logic        flush,
   input  logic [31:0] instruction,
   input  logic [31:0] pc_plus4,
   output logic [31:0] ifid_instruction,
   output logic [31:0] ifid_pc_plus4,
   output logic        ifid_valid
);

   // Flush beats write so a squashed wrong-path fetch never appears valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ifid_instruction <= NOP_WORD;
         ifid_pc_plus4    <= 32'd0;
         ifid_valid       <= 1'b0;
      end else if (flush) begin
         ifid_instruction <= NOP_WORD;
         ifid_pc_plus4    <= 32'd0;
         ifid_valid       <= 1'b0;
      end else if (write) begin
         ifid_instruction <= instruction;
         ifid_pc_plus4    <= pc_plus4;
         ifid_valid       <= 1'b1;
      end
   end

endmodule

// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - PC register, PC+4 adder, boot/run/halt FSM and fetch counter
module pc_fetch_stage
   import pc_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
)
(
   input  logic             Clk,
   input  logic             Rst,
   pc_fetch_stage_if.slave  bus
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  pc_plus4;
   logic [31:0]  fetch_count;
   logic         halted;
   logic         ifid_write;
   logic         ifid_flush;
   logic         take_load;
   logic [31:0]  ifid_instruction;
   logic [31:0]  ifid_pc_plus4;
   logic         ifid_valid;

   assign pc_plus4  = next_seq_pc(pc);
   assign take_load = (state == ST_RUN) && !bus.IFIDFlush && bus.IFIDWrite;

   // Once halted, any write or flush request turns into a bubble load.
   always_comb begin
      ifid_write = 1'b0;
      ifid_flush = 1'b0;
      case (state)
         ST_RUN: begin
            ifid_write = bus.IFIDWrite;
            ifid_flush = bus.IFIDFlush;
         end
         ST_HALTED: begin
            ifid_flush = bus.IFIDFlush | bus.IFIDWrite;
         end
         default: begin
            ifid_write = 1'b0;
            ifid_flush = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state       <= ST_BOOT;
         pc          <= RESET_PC;
         fetch_count <= 32'd0;
         halted      <= 1'b0;
      end else begin
         case (state)
            ST_BOOT: begin
               state <= ST_RUN;
            end
            ST_RUN: begin
               if (bus.PCWrite) begin
                  pc <= bus.PCNext;
               end
               if (take_load) begin
                  fetch_count <= fetch_count + 32'd1;
                  if (bus.Instruction == HALT_WORD) begin
                     state  <= ST_HALTED;
                     halted <= 1'b1;
                  end
               end
            end
            ST_HALTED: begin
               state <= ST_HALTED;
            end
            default: begin
               state  <= ST_BOOT;
               halted <= 1'b0;
            end
         endcase
      end
   end

   if_id_register u_if_id (
      .clk              (Clk),
      .rst              (Rst),
      .write            (ifid_write),
      .flush            (ifid_flush),
      .instruction      (bus.Instruction),
      .pc_plus4         (pc_plus4),
      .ifid_instruction (ifid_instruction),
      .ifid_pc_plus4    (ifid_pc_plus4),
      .ifid_valid       (ifid_valid)
   );

   assign bus.PCAddr           = pc;
   assign bus.PCPlus4          = pc_plus4;
   assign bus.IFID_Instruction = ifid_instruction;
   assign bus.IFID_PCPlus4     = ifid_pc_plus4;
   assign bus.IFID_Valid       = ifid_valid;
   assign bus.Halted           = halted;
   assign bus.FetchCount       = fetch_count;

endmodule
